seg_scan_disp: RTL and testbench
================================

// Module: seg_scan_disp
// PURPOSE
//  Parametrised successor of the per-digit display-value mux: accepts NUM_FIELDS binary
//  fields (e.g. hour/min/sec, month/day, year), converts each to BCD with a serial
//  shift-add-3 engine, commits the result atomically to a display buffer and time-
//  multiplexes it onto a 7-seg digit bus. Sits between the timekeeping core and the segment decoder.
// PARAMETERS
//  NUM_FIELDS   3         number of binary fields per update
//  FIELD_W      7         width of each binary field (bits)
//  FIELD_DIGITS 2         BCD digits shown per field; NUM_DIGITS = NUM_FIELDS*FIELD_DIGITS
//  SCAN_DIV     50000     clk cycles per digit dwell (>=1)
//  BLINK_DIV    25000000  clk cycles per blink half-period (>=1)
// PORTS
//  clk         in   1                        system clock
//  rst         in   1                        synchronous, active-high reset
//  upd_valid   in   1                        new field set offered
//  upd_ready   out  1                        engine idle, can accept
//  upd_data    in   NUM_FIELDS*FIELD_W       field k = upd_data[k*FIELD_W +: FIELD_W]
//  blink_on    in   1                        request blinking of one field (edit mode)
//  blink_field in   $clog2(NUM_FIELDS)       field index to blink
//  busy        out  1                        conversion in progress
//  digit_sel   out  NUM_DIGITS               one-hot active-high digit enable
//  digit_val   out  4                        BCD 0-9; 4'hF blank; 4'hE overflow
// BEHAVIOUR
//  - Reset: upd_ready=1, busy=0, digit_sel=0, digit_val=4'hF, buffer all 4'hF, counters 0, FSM IDLE.
//  - Handshake: transfer when upd_valid&&upd_ready; data captured that cycle; upd_ready=!busy.
//  - FSM IDLE->CONV->COMMIT->IDLE. CONV handles fields 0..NUM_FIELDS-1 in order, FIELD_W+1
//    cycles each (1 load + FIELD_W shift/add-3). COMMIT writes all digits in one cycle.
//    Latency accept->buffer updated = NUM_FIELDS*(FIELD_W+1)+1 cycles; no partial (torn) display.
//  - Internal BCD width covers 2^FIELD_W-1; if field value >= 10^FIELD_DIGITS all that field's digits = 4'hE.
//  - Layout: digit 0 = leftmost = MS digit of field NUM_FIELDS-1; field 0 LS digit = digit NUM_DIGITS-1.
//  - Scan: prescaler 0..SCAN_DIV-1; at terminal count index advances, NUM_DIGITS-1 wraps to 0.
//    First terminal after reset enables digit 0. digit_sel/digit_val registered, change together.
//  - Upd during busy: ignored (upd_ready=0); a held upd_valid is accepted the cycle after COMMIT.
//  - Reset mid-conversion: conversion aborted, buffer blanked, no commit.
//  - blink_field >= NUM_FIELDS: no field blinks.
// CONFIGURATION
//  SEG_SCAN_BLINK_EN defined: blink counter toggles phase every BLINK_DIV cycles (phase=on at
//    reset); while blink_on and phase=off, digits of blink_field output 4'hF; buffer untouched.
//  Undefined: blink counter absent, blink_on/blink_field ignored, never blanks.
// STRUCTURE
//  Package seg_disp_pkg: DIG_BLANK=4'hF, DIG_ERR=4'hE, FSM state enum, clog2 helper.
//  Sub-module bin2bcd_serial: one-field shift-add-3 converter (start/done, FIELD_W-parameterised).
// TESTING (sim: FIELD_W=7, FIELD_DIGITS=2, NUM_FIELDS=3, SCAN_DIV=4, BLINK_DIV=16)
//  1 upd {23,59,7} -> digits 0..5 = 2,3,5,9,0,7; buffer changes exactly 25 cycles after accept.
//  2 field0=100, others 12,34 -> digits 4,5 = E,E; digits 0..3 = 1,2,3,4.
//  3 two back-to-back valids -> second stalls (upd_ready=0) until COMMIT; then accepted, both shown in order.
//  4 rst asserted at cycle 10 of CONV -> digit_val=F, digit_sel=0 next cycle; no commit follows.
//  5 scan 30 dwells -> digit_sel walks 000001..100000 each 4 cycles, wraps to digit 0.
//  6 BLINK_EN, blink_on=1, field=1 -> digits 2,3 alternate value/F every 16 cycles; undefined -> steady.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared constants, FSM state type and elaboration helpers
// for the scanned BCD display path.
package seg_disp_pkg;

  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_ERR   = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_COMMIT
  } conv_state_e;

  // Never returns less than 1 so counters always have a bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((32'd1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int dec_digits(input int w);
    longint v;
    int     d;
    v = (longint'(1) << w) - 1;
    d = 1;
    for (int i = 0; i < 20; i++)
      if (v >= 10) begin
        v = v / 10;
        d++;
      end
    return d;
  endfunction

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++)
      p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/seg_scan_disp_bin2bcd.sv
// Serial shift-add-3 converter for one binary field:
// one load cycle, then FIELD_W shift cycles.
module bin2bcd_serial
  import seg_disp_pkg::*;
#(
  parameter int FIELD_W = 7,
  parameter int BCD_D   = dec_digits(FIELD_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [FIELD_W-1:0]   bin_i,
  output logic                 done_o,
  output logic [4*BCD_D-1:0]   bcd_o
);

  localparam int CW = clog2(FIELD_W + 1);

  logic [FIELD_W-1:0] sh_q, sh_d;
  logic [4*BCD_D-1:0] bcd_q, bcd_d;
  logic [4*BCD_D-1:0] adj, nxt;
  logic [CW-1:0]      cnt_q, cnt_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_D; i++)
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    nxt = {adj[4*BCD_D-2:0], sh_q[FIELD_W-1]};
  end

  always_comb begin
    sh_d  = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (start_i) begin
      sh_d  = bin_i;
      bcd_d = '0;
      cnt_d = CW'(FIELD_W);
    end else if (cnt_q != '0) begin
      sh_d  = sh_q << 1;
      bcd_d = nxt;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  // Result is offered on the final shift so the caller can
  // latch it on the same edge the shift completes.
  assign done_o = (cnt_q == CW'(1)) && !start_i;
  assign bcd_o  = nxt;

endmodule

// File: rtl/seg_scan_disp.sv
// Multi-field binary->BCD display buffer with digit scanning.
// Optional blinking of one field under SEG_SCAN_BLINK_EN.
module seg_scan_disp
  import seg_disp_pkg::*;
#(
  parameter int NUM_FIELDS   = 3,
  parameter int FIELD_W      = 7,
  parameter int FIELD_DIGITS = 2,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_DIV    = 25000000,
  localparam int NUM_DIGITS  = NUM_FIELDS * FIELD_DIGITS,
  localparam int FSEL_W      = clog2(NUM_FIELDS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          upd_valid,
  output logic                          upd_ready,
  input  logic [NUM_FIELDS*FIELD_W-1:0] upd_data,
  input  logic                          blink_on,
  input  logic [FSEL_W-1:0]             blink_field,
  output logic                          busy,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic [3:0]                    digit_val
);

  localparam int BCD_D = dec_digits(FIELD_W);
  localparam int PH_W  = clog2(FIELD_W + 1);
  localparam int FLD_W = clog2(NUM_FIELDS);
  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam int SC_W  = clog2(SCAN_DIV);
  localparam int EXT_W = 4 * (BCD_D + FIELD_DIGITS);
  localparam logic [63:0] OVF_LIM = 64'(pow10(FIELD_DIGITS));

  conv_state_e state_q, state_d;
  logic [FLD_W-1:0] fld_q, fld_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [NUM_FIELDS*FIELD_W-1:0] data_q;
  logic [4*BCD_D-1:0] stage_q [NUM_FIELDS];
  logic [3:0] buf_q [NUM_DIGITS];
  logic [3:0] buf_d [NUM_DIGITS];

  logic acc, start, commit, cv_done;
  logic [FIELD_W-1:0] cur_bin;
  logic [4*BCD_D-1:0] cv_bcd;

  assign busy      = (state_q != ST_IDLE);
  assign upd_ready = !busy;
  assign acc       = upd_valid && upd_ready;

  always_comb begin
    state_d = state_q;
    fld_d   = fld_q;
    ph_d    = ph_q;
    start   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          state_d = ST_CONV;
          fld_d   = '0;
          ph_d    = '0;
        end
      end
      ST_CONV: begin
        start = (ph_q == '0);
        if (ph_q == PH_W'(FIELD_W)) begin
          ph_d = '0;
          if (fld_q == FLD_W'(NUM_FIELDS - 1))
            state_d = ST_COMMIT;
          else
            fld_d = fld_q + 1'b1;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cur_bin = '0;
    for (int k = 0; k < NUM_FIELDS; k++)
      if (fld_q == FLD_W'(k))
        cur_bin = data_q[k*FIELD_W +: FIELD_W];
  end

  bin2bcd_serial #(
    .FIELD_W (FIELD_W),
    .BCD_D   (BCD_D)
  ) u_b2b (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .bin_i   (cur_bin),
    .done_o  (cv_done),
    .bcd_o   (cv_bcd)
  );

  // Digit 0 is leftmost: highest field, most significant digit.
  always_comb begin
    logic [EXT_W-1:0] ext;
    logic             ovf;
    ext = '0;
    ovf = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++)
      buf_d[d] = DIG_BLANK;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      ext = '0;
      ext[4*BCD_D-1:0] = stage_q[k];
      ovf = 64'(data_q[k*FIELD_W +: FIELD_W]) >= OVF_LIM;
      for (int j = 0; j < FIELD_DIGITS; j++)
        buf_d[NUM_DIGITS-1-(k*FIELD_DIGITS+j)] =
          ovf ? DIG_ERR : ext[4*j +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fld_q   <= '0;
      ph_q    <= '0;
      data_q  <= '0;
      for (int k = 0; k < NUM_FIELDS; k++)
        stage_q[k] <= '0;
      for (int d = 0; d < NUM_DIGITS; d++)
        buf_q[d] <= DIG_BLANK;
    end else begin
      state_q <= state_d;
      fld_q   <= fld_d;
      ph_q    <= ph_d;
      if (acc)
        data_q <= upd_data;
      for (int k = 0; k < NUM_FIELDS; k++)
        if (cv_done && fld_q == FLD_W'(k))
          stage_q[k] <= cv_bcd;
      if (commit)
        for (int d = 0; d < NUM_DIGITS; d++)
          buf_q[d] <= buf_d[d];
    end
  end

  logic [SC_W-1:0]       pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  on_q, on_d, tc;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [3:0]            val_q, val_d;
  logic                  blank;

  assign tc = (pre_q == SC_W'(SCAN_DIV - 1));

  // The first terminal count only arms the scan on digit 0.
  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    on_d  = on_q;
    if (tc) begin
      pre_d = '0;
      on_d  = 1'b1;
      if (on_q)
        idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int BL_W = clog2(BLINK_DIV);

  logic [BL_W-1:0] bl_cnt_q;
  logic            bl_ph_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bl_cnt_q <= '0;
      bl_ph_q  <= 1'b1;
    end else if (bl_cnt_q == BL_W'(BLINK_DIV - 1)) begin
      bl_cnt_q <= '0;
      bl_ph_q  <= !bl_ph_q;
    end else begin
      bl_cnt_q <= bl_cnt_q + 1'b1;
    end
  end

  // Out-of-range field indices match no digit, so nothing blinks.
  always_comb begin
    blank = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++)
      if (idx_d == IDX_W'(d) && blink_on && !bl_ph_q &&
          int'(blink_field) == (NUM_DIGITS - 1 - d) / FIELD_DIGITS)
        blank = 1'b1;
  end
`else
  logic unused_blink;
  assign unused_blink = ^{blink_on, blink_field, BLINK_DIV[0]};
  assign blank = 1'b0;
`endif

  always_comb begin
    sel_d = '0;
    val_d = DIG_BLANK;
    if (on_d) begin
      sel_d[idx_d] = 1'b1;
      val_d = blank ? DIG_BLANK : buf_q[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= '0;
      on_q  <= 1'b0;
      sel_q <= '0;
      val_q <= DIG_BLANK;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      on_q  <= on_d;
      sel_q <= sel_d;
      val_q <= val_d;
    end
  end

  assign digit_sel = sel_q;
  assign digit_val = val_q;

endmodule

// File: tb/tb_seg_scan_disp.sv
// Directed bench for seg_scan_disp: conversion latency,
// overflow, stall, reset abort, scan walk and blinking.
module tb_seg_scan_disp;

  localparam int NF = 3;
  localparam int FD = 2;
  localparam int ND = 6;
`ifdef SEG_SCAN_BLINK_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          upd_valid = 1'b0;
  logic          upd_ready;
  logic [20:0]   upd_data = '0;
  logic          blink_on = 1'b0;
  logic [1:0]    blink_field = 2'd0;
  logic          busy;
  logic [ND-1:0] digit_sel;
  logic [3:0]    digit_val;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int fv [NF];
  bit loaded = 1'b0;
  int n;

  seg_scan_disp #(
    .NUM_FIELDS   (3),
    .FIELD_W      (7),
    .FIELD_DIGITS (2),
    .SCAN_DIV     (4),
    .BLINK_DIV    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_data    (upd_data),
    .blink_on    (blink_on),
    .blink_field (blink_field),
    .busy        (busy),
    .digit_sel   (digit_sel),
    .digit_val   (digit_val)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = rst ? 0 : cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sel_idx(input logic [ND-1:0] s);
    int r;
    r = -1;
    for (int i = 0; i < ND; i++)
      if (s[i]) r = i;
    return r;
  endfunction

  function automatic int exp_dig(input int d);
    int k, j, v;
    if (!loaded) return 15;
    k = (ND - 1 - d) / FD;
    j = (ND - 1 - d) % FD;
    v = fv[k];
    if (BL && blink_on && int'(blink_field) == k &&
        (((cyc - 1) / 16) % 2) == 1)
      return 15;
    if (v >= 100) return 14;
    return (j == 0) ? v % 10 : (v / 10) % 10;
  endfunction

  task automatic set_fv(input int a2, input int a1, input int a0);
    fv[2] = a2;
    fv[1] = a1;
    fv[0] = a0;
    loaded = 1'b1;
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic offer(input int a2, input int a1, input int a0);
    upd_data  = {7'(a2), 7'(a1), 7'(a0)};
    upd_valid = 1'b1;
    chk("offer_ready", upd_ready, 1);
    @(negedge clk);
    upd_valid = 1'b0;
    chk("offer_busy", busy, 1);
  endtask

  task automatic scan_chk(input string tag, input int k);
    int i;
    repeat (k) begin
      @(negedge clk);
      i = sel_idx(digit_sel);
      chk({tag, "_onehot"}, 32'($onehot(digit_sel)), 1);
      chk(tag, digit_val, (i < 0) ? 15 : exp_dig(i));
    end
  endtask

  initial begin
    tick(3);
    chk("rst_ready", upd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sel", digit_sel, 0);
    chk("rst_val", digit_val, 4'hF);
    rst = 1'b0;
    tick(6);

    // 1: latency and layout
    offer(23, 59, 7);
    tick(24);
    chk("t1_commit_busy", busy, 1);
    tick(1);
    chk("t1_idle", busy, 0);
    chk("t1_old_val", digit_val, 4'hF);
    tick(1);
    set_fv(23, 59, 7);
    chk("t1_new_val", digit_val, exp_dig(sel_idx(digit_sel)));
    scan_chk("t1_disp", 24);

    // 2: overflow on field 0
    offer(12, 34, 100);
    tick(26);
    set_fv(12, 34, 100);
    scan_chk("t2_disp", 24);

    // 3: held valid stalls until commit
    upd_data  = {7'd45, 7'd6, 7'd78};
    upd_valid = 1'b1;
    @(negedge clk);
    upd_data = {7'd9, 7'd10, 7'd99};
    n = 0;
    while (!upd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t3_stall_len", n, 25);
    @(negedge clk);
    upd_valid = 1'b0;
    chk("t3_second_busy", busy, 1);
    set_fv(45, 6, 78);
    scan_chk("t3_first", 20);
    tick(5);
    set_fv(9, 10, 99);
    scan_chk("t3_second", 24);

    // 4: reset during conversion, then 5: scan walk
    offer(1, 2, 3);
    tick(10);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_sel", digit_sel, 0);
    chk("t4_val", digit_val, 4'hF);
    chk("t4_busy", busy, 0);
    chk("t4_ready", upd_ready, 1);
    rst = 1'b0;
    loaded = 1'b0;
    repeat (124) begin
      @(negedge clk);
      chk("t5_sel", digit_sel,
          (cyc < 4) ? 0 : (1 << (((cyc - 4) / 4) % ND)));
      chk("t4_no_commit", digit_val, 4'hF);
    end

    // 6: blinking of field 1, then an out-of-range field
    offer(23, 59, 7);
    tick(26);
    set_fv(23, 59, 7);
    blink_on    = 1'b1;
    blink_field = 2'd1;
    tick(1);
    scan_chk("t6_blink", 64);
    blink_field = 2'd3;
    tick(1);
    scan_chk("t6_range", 32);
    blink_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
